// File: rtl/bk_alu_sequencer.sv
// Sequencer for a 4-bit Brent-Kung ALU. It time-multiplexes one external
// black cell (Go = Gi | Pi&Gk, Po = Pi&Pk) over the four prefix nodes of a
// 4-bit adder. Operations are accepted one at a time on a valid/ready input
// and are returned on a valid/ready output. Logic ops skip the prefix schedule.
//
// Schedule (ADD/SUB): IDLE -> PRE -> L1A -> L1B -> L2 -> L3 -> DONE -> IDLE
// Schedule (AND/XOR): IDLE -> PRE -> DONE -> IDLE
// DONE spends one cycle forming the result before out_valid rises. This gives
// a latency of 2+4*CELL_LAT cycles for arithmetic and 2 cycles for logic ops.
module bk_alu_sequencer #(
  parameter int WIDTH    = 4,  // only 4 is meaningful: the prefix schedule is fixed
  parameter int CELL_LAT = 1   // cycles per shared-cell evaluation, 1..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             cell_gi,
  output logic             cell_pi,
  output logic             cell_gk,
  output logic             cell_pk,
  input  logic             cell_go,
  input  logic             cell_po,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_L1A,
    S_L1B,
    S_L2,
    S_L3,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Last cycle of a cell state; the cell result is sampled only then.
  localparam logic [1:0] LAT_LAST = 2'(CELL_LAT - 1);

  state_t state, next_state;

  // Captured operation
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic             cin_r;

  // Bit-level generate/propagate after PRE (g_r[0] already includes c0)
  logic [WIDTH-1:0] g_r, p_r;
  logic             c0_r;

  // Prefix-node results collected from the shared cell
  logic g10, p10, g32, p32, g30, g20;

  // Registered drive to the shared cell: {gi, pi, gk, pk}
  logic [3:0] cell_r;
  logic [1:0] lat_cnt;

  // Output registers
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r, ovf_r, zero_r;

  // PRE-stage combinational terms
  logic [WIDTH-1:0] b_eff, g_pre, p_pre, logic_res, sum;
  logic             c0;
  logic             cell_done;
  logic             is_logic;

  assign is_logic  = op_r[1];
  assign cell_done = (lat_cnt == LAT_LAST);

  // PRE datapath: operand conditioning, bit g/p, logic result, final sum
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    b_eff     = b_r;
    c0        = 1'b0;
    g_pre     = '0;
    p_pre     = '0;
    logic_res = '0;
    sum       = '0;

    if (op_r == OP_SUB) begin
      b_eff = ~b_r;
      c0    = 1'b1;
    end else if (op_r == OP_ADD) begin
      c0 = cin_r;
    end

    p_pre    = a_r ^ b_eff;
    g_pre    = a_r & b_eff;
    g_pre[0] = g_pre[0] | (p_pre[0] & c0);

    logic_res = (op_r == OP_AND) ? (a_r & b_r) : (a_r ^ b_r);

    // Carries into each bit: c0, c1 = g0 (post-PRE), c2 = G10, c3 = G20
    sum = p_r ^ {g20, g10, g_r[0], c0_r};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (in_valid) next_state = S_PRE;
      S_PRE:  next_state = is_logic ? S_DONE : S_L1A;
      S_L1A:  if (cell_done) next_state = S_L1B;
      S_L1B:  if (cell_done) next_state = S_L2;
      S_L2:   if (cell_done) next_state = S_L3;
      S_L3:   if (cell_done) next_state = S_DONE;
      S_DONE: if (out_valid_r && out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cin_r <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      a_r   <= in_a;
      b_r   <= in_b;
      op_r  <= in_op;
      cin_r <= in_cin;
    end
  end

  // Prefix schedule: drive the shared cell and collect its results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r     <= '0;
      p_r     <= '0;
      c0_r    <= 1'b0;
      g10     <= 1'b0;
      p10     <= 1'b0;
      g32     <= 1'b0;
      p32     <= 1'b0;
      g30     <= 1'b0;
      g20     <= 1'b0;
      cell_r  <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_PRE: begin
          g_r     <= g_pre;
          p_r     <= p_pre;
          c0_r    <= c0;
          lat_cnt <= '0;
          if (!is_logic) cell_r <= {g_pre[1], p_pre[1], g_pre[0], p_pre[0]};
        end
        S_L1A, S_L1B, S_L2, S_L3: begin
          if (!cell_done) begin
            lat_cnt <= lat_cnt + 2'd1;
          end else begin
            lat_cnt <= '0;
            case (state)
              S_L1A: begin
                g10    <= cell_go;
                p10    <= cell_po;
                cell_r <= {g_r[3], p_r[3], g_r[2], p_r[2]};
              end
              S_L1B: begin
                g32    <= cell_go;
                p32    <= cell_po;
                cell_r <= {cell_go, cell_po, g10, p10};
              end
              S_L2: begin
                g30    <= cell_go;
                cell_r <= {g_r[2], p_r[2], g10, p10};
              end
              default: begin
                g20    <= cell_go;
                cell_r <= '0;
              end
            endcase
          end
        end
        default: cell_r <= '0;
      endcase
    end
  end

  // Output registers: logic results load in PRE, sums load in DONE's first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      if (state == S_PRE && is_logic) begin
        result_r <= logic_res;
        cout_r   <= 1'b0;
        ovf_r    <= 1'b0;
        zero_r   <= (logic_res == '0);
      end
      if (state == S_DONE) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          if (!is_logic) begin
            result_r <= sum;
            cout_r   <= g30;
            ovf_r    <= g20 ^ g30;
            zero_r   <= (sum == '0);
          end
        end else if (out_ready) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign cell_gi    = cell_r[3];
  assign cell_pi    = cell_r[2];
  assign cell_gk    = cell_r[1];
  assign cell_pk    = cell_r[0];
  assign out_valid  = out_valid_r;
  assign out_result = result_r;
  assign out_cout   = cout_r;
  assign out_ovf    = ovf_r;
  assign out_zero   = zero_r;

endmodule

// File: tb/tb_bk_alu_sequencer.sv
// Bench for bk_alu_sequencer: a CELL_LAT=1 instance runs a vector table plus
// backpressure and reset sequences; a CELL_LAT=3 instance checks the slow cell.
// Each instance gets its own behavioural black cell.
module tb_bk_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid0, in_valid1;
  logic [3:0] in_a, in_b;
  logic [1:0] in_op;
  logic       in_cin;
  logic       out_ready;

  logic       rdy0, gi0, pi0, gk0, pk0, go0, po0, ov0, co0, of0, z0;
  logic [3:0] res0;
  logic       rdy1, gi1, pi1, gk1, pk1, go1, po1, ov1, co1, of1, z1;
  logic [3:0] res1;

  int checks   = 0;
  int failures = 0;

  // Selects which instance the shared tasks observe and drive
  logic sel;

  logic       m_ready, m_valid, m_cout, m_ovf, m_zero;
  logic [3:0] m_res, m_cells;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [1:0]  op;
    logic        cin;
    logic [3:0]  res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] cells;  // {L1A, L1B, L2, L3} patterns, each {gi,pi,gk,pk}
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  // Behavioural shared black cells
  assign go0 = gi0 | (pi0 & gk0);
  assign po0 = pi0 & pk0;
  assign go1 = gi1 | (pi1 & gk1);
  assign po1 = pi1 & pk1;

  assign m_ready = sel ? rdy1 : rdy0;
  assign m_valid = sel ? ov1  : ov0;
  assign m_res   = sel ? res1 : res0;
  assign m_cout  = sel ? co1  : co0;
  assign m_ovf   = sel ? of1  : of0;
  assign m_zero  = sel ? z1   : z0;
  assign m_cells = sel ? {gi1, pi1, gk1, pk1} : {gi0, pi0, gk0, pk0};

  bk_alu_sequencer #(.WIDTH(4), .CELL_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .cell_gi(gi0), .cell_pi(pi0), .cell_gk(gk0), .cell_pk(pk0),
    .cell_go(go0), .cell_po(po0),
    .out_valid(ov0), .out_ready(out_ready),
    .out_result(res0), .out_cout(co0), .out_ovf(of0), .out_zero(z0)
  );

  bk_alu_sequencer #(.WIDTH(4), .CELL_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .cell_gi(gi1), .cell_pi(pi1), .cell_gk(gk1), .cell_pk(pk1),
    .cell_go(go1), .cell_po(po1),
    .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_cout(co1), .out_ovf(of1), .out_zero(z1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) in_valid1 = v;
    else     in_valid0 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check($sformatf("%s result", tag), m_res,  v.res);
    check($sformatf("%s cout",   tag), m_cout, v.cout);
    check($sformatf("%s ovf",    tag), m_ovf,  v.ovf);
    check($sformatf("%s zero",   tag), m_zero, v.zero);
  endtask

  // Issue one op, follow the cell schedule, check latency, outputs and drain
  task automatic run_op(input vec_t v, input int lat, input string tag);
    int         cnt;
    int         idx;
    bit         done;
    int         exp_lat;
    logic [3:0] exp_cell;
    exp_lat = v.op[1] ? 2 : 2 + 4 * lat;
    check($sformatf("%s in_ready idle", tag), m_ready, 1'b1);
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin;
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    // Scramble inputs: the captured operation must not follow them
    in_a = ~v.a; in_b = ~v.b; in_op = ~v.op; in_cin = ~v.cin;
    check($sformatf("%s in_ready busy", tag), m_ready, 1'b0);
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 64) begin
      step();
      cnt++;
      if (m_valid) begin
        done = 1'b1;
      end else begin
        exp_cell = 4'h0;
        if (!v.op[1] && cnt <= 4 * lat) begin
          idx      = (cnt - 1) / lat;
          exp_cell = v.cells[15 - 4 * idx -: 4];
        end
        check($sformatf("%s cell c%0d", tag, cnt), m_cells, exp_cell);
      end
    end
    check($sformatf("%s latency", tag), cnt, exp_lat);
    check_outputs(tag, v);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("%s valid drop", tag), m_valid, 1'b0);
    check($sformatf("%s ready back", tag), m_ready, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   cnt;

    //          a     b     op     cin   res   cout  ovf   zero  cells
    vecs[0] = '{4'h7, 4'h5, 2'b00, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 16'h622A};  // ADD 7+5
    vecs[1] = '{4'hF, 4'h0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 16'h7577};  // ADD F+0+1
    vecs[2] = '{4'h3, 4'h5, 2'b01, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 16'hB422};  // SUB 3-5
    vecs[3] = '{4'h5, 4'h5, 2'b01, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 16'h7577};  // SUB 5-5, cin ignored
    vecs[4] = '{4'hC, 4'hA, 2'b10, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 16'h0000};  // AND
    vecs[5] = '{4'hC, 4'hA, 2'b11, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 16'h0000};  // XOR
    vecs[6] = '{4'h8, 4'h8, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0880};  // ADD 8+8 overflow
    vecs[7] = '{4'h0, 4'h1, 2'b01, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h4544};  // SUB 0-1, c0 forced 1
    vecs[8] = '{4'h0, 4'hF, 2'b10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000};  // AND zero, cin ignored

    sel = 1'b0;
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",   rdy0, 1'b1);
    check("reset out_valid",  ov0,  1'b0);
    check("reset result",     res0, 4'h0);
    check("reset flags",      {co0, of0, z0}, 3'b000);
    check("reset cells",      {gi0, pi0, gk0, pk0}, 4'h0);
    check("reset slow ready", rdy1, 1'b1);
    rst = 1'b0;
    step();

    // Vector table on the CELL_LAT=1 instance
    foreach (vecs[i]) run_op(vecs[i], 1, $sformatf("vec%0d", i));

    // Backpressure: hold out_ready low for 5 cycles; a stray request must not queue
    v = vecs[0];
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    cnt = 0;
    while (!ov0 && cnt < 64) begin
      step();
      cnt++;
    end
    check("bp latency", cnt, 6);
    for (int k = 0; k < 5; k++) begin
      check_outputs($sformatf("bp hold%0d", k), v);
      check($sformatf("bp valid%0d", k), ov0, 1'b1);
      check($sformatf("bp ready%0d", k), rdy0, 1'b0);
      if (k == 2) begin
        in_a = 4'h1; in_b = 4'h1; in_op = 2'b10; in_cin = 1'b0;
        in_valid0 = 1'b1;
      end else begin
        in_valid0 = 1'b0;
      end
      step();
    end
    in_valid0 = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp released valid", ov0, 1'b0);
    check("bp released ready", rdy0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp no queue valid%0d", k), ov0, 1'b0);
      check($sformatf("bp no queue ready%0d", k), rdy0, 1'b1);
    end
    run_op(vecs[5], 1, "bp next");

    // Reset asserted between edges while in L2
    v = vecs[0];
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    repeat (3) step();
    check("rst mid L2 cells", {gi0, pi0, gk0, pk0}, 4'h2);
    #2;
    rst = 1'b1;
    #1;
    check("rst async valid", ov0, 1'b0);
    check("rst async cells", {gi0, pi0, gk0, pk0}, 4'h0);
    check("rst async ready", rdy0, 1'b1);
    #2;
    rst = 1'b0;
    step();
    check("rst after valid", ov0, 1'b0);
    v = '{4'h1, 4'h1, 2'b00, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 16'h2000};
    run_op(v, 1, "rst add1+1");

    // Slow cell: CELL_LAT=3
    sel = 1'b1;
    v = '{4'h9, 4'h9, 2'b00, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 16'h2880};
    run_op(v, 3, "lat3 add");
    run_op(vecs[4], 3, "lat3 and");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
